max7219_serial_driver: RTL and testbench

//  Serialises eight 7-segment digit bytes into MAX7219 SPI-style words (o_serial_dout/clk/load).

---
 rtl/max7219_serial_driver.sv | 215 +++++++++++++++++++++
 tb/tb_max7219_serial_driver.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_serial_driver.sv
// ---------------------------------------------------------------------------
// max7219_serial_driver
//
// Serialises eight 7-segment digit bytes into MAX7219 16-bit words
// {4'h0, addr[3:0], data[7:0]}, MSB first, on a three-wire interface
// (data / clock / load). The first frame after reset is preceded by the
// five configuration words (decode, intensity, scan limit, shutdown,
// display test); every frame then sends the eight digit registers.
//
// Build option:
//   MAX7219_REINIT_EN  defined   -> configuration words precede every frame
//                      undefined -> configuration words only in the first
//                                   frame after reset
//
// Parameters:
//   CLK_DIV     i_clk cycles per serial-clock half period (>= 1)
//   INTENSITY   value written to the intensity register (0x0A)
//   SCAN_LIMIT  value written to the scan-limit register (0x0B)
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_en           enable, qualifies i_start only
//   i_start        frame request strobe
//   i_digits       digit k = i_digits[8k+7:8k] (bit7 = DP, bits6:0 = A..G)
//   o_busy         frame in progress
//   o_done         one-cycle pulse when a frame completes
//   o_serial_dout  serial data, MSB first
//   o_serial_clk   serial clock, idle low, sampled by the MAX7219 on rise
//   o_serial_load  latch strobe, idle low, one pulse per word
// ---------------------------------------------------------------------------
module max7219_serial_driver #(
    parameter int         CLK_DIV    = 2,
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_start,
    input  logic [63:0] i_digits,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_serial_dout,
    output logic        o_serial_clk,
    output logic        o_serial_load
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    // Word index space: 0..4 are config words, 5..12 are digits 0..7.
    localparam logic [3:0] LAST_CFG    = 4'd4;
    localparam logic [3:0] FIRST_DIGIT = 4'd5;
    localparam logic [3:0] LAST_WORD   = 4'd12;

`ifdef MAX7219_REINIT_EN
    localparam logic REINIT = 1'b1;
`else
    localparam logic REINIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_GAP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_half;
    logic [3:0]      r_bit;
    logic [3:0]      r_word_idx;
    logic [63:0]     r_snap;
    logic            r_cfg_sent;
    logic            r_busy;
    logic            r_done;
    logic            r_dout;
    logic            r_sclk;
    logic            r_load;

    logic [15:0]     w_word;
    logic [3:0]      w_bit_dn;
    logic            w_half_end;
    logic [3:0]      w_start_idx;

    function automatic logic [15:0] word_of(input logic [3:0] idx,
                                            input logic [63:0] snap);
        logic [2:0]  k;
        logic [15:0] w;
        k = 3'(idx - FIRST_DIGIT);
        case (idx)
            4'd0:    w = 16'h0900;
            4'd1:    w = {8'h0A, 4'h0, INTENSITY};
            4'd2:    w = {8'h0B, 5'h0, SCAN_LIMIT};
            4'd3:    w = 16'h0C01;
            4'd4:    w = 16'h0F00;
            default: w = {4'h0, idx - 4'd4, snap[{k, 3'b000} +: 8]};
        endcase
        return w;
    endfunction

    always_comb begin
        w_word      = word_of(r_word_idx, r_snap);
        w_bit_dn    = r_bit - 4'd1;
        w_half_end  = (r_half == HALF_LAST);
        w_start_idx = (r_cfg_sent && !REINIT) ? FIRST_DIGIT : 4'd0;
    end

    // Every word starts with the 4'h0 nibble, so the first bit driven at
    // the start of any word is always 0 and needs no word lookup.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_half     <= '0;
            r_bit      <= '0;
            r_word_idx <= '0;
            r_snap     <= '0;
            r_cfg_sent <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dout     <= 1'b0;
            r_sclk     <= 1'b0;
            r_load     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_sclk <= 1'b0;
                    r_load <= 1'b0;
                    r_dout <= 1'b0;
                    if (i_start && i_en) begin
                        r_snap     <= i_digits;
                        r_word_idx <= w_start_idx;
                        r_bit      <= 4'd15;
                        r_half     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT_LO;
                    end
                end
                S_SHIFT_LO: begin
                    if (w_half_end) begin
                        r_half  <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_half <= r_half + CW'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_half_end) begin
                        r_half <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit == 4'd0) begin
                            r_load  <= 1'b1;
                            r_dout  <= 1'b0;
                            r_state <= S_LATCH;
                        end else begin
                            r_bit   <= w_bit_dn;
                            r_dout  <= w_word[w_bit_dn];
                            r_state <= S_SHIFT_LO;
                        end
                    end else begin
                        r_half <= r_half + CW'(1);
                    end
                end
                S_LATCH: begin
                    if (w_half_end) begin
                        r_half  <= '0;
                        r_load  <= 1'b0;
                        r_state <= S_GAP;
                        if (r_word_idx == LAST_CFG) begin
                            r_cfg_sent <= 1'b1;
                        end
                    end else begin
                        r_half <= r_half + CW'(1);
                    end
                end
                S_GAP: begin
                    if (w_half_end) begin
                        r_half <= '0;
                        if (r_word_idx == LAST_WORD) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_word_idx <= r_word_idx + 4'd1;
                            r_bit      <= 4'd15;
                            r_dout     <= 1'b0;
                            r_state    <= S_SHIFT_LO;
                        end
                    end else begin
                        r_half <= r_half + CW'(1);
                    end
                end
                S_DONE: begin
                    // i_start is deliberately not examined here.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_serial_dout = r_dout;
    assign o_serial_clk  = r_sclk;
    assign o_serial_load = r_load;

endmodule

// File: tb/tb_max7219_serial_driver.sv
// ---------------------------------------------------------------------------
// tb_max7219_serial_driver
//
// Directed bench for max7219_serial_driver (CLK_DIV=2, INTENSITY=8,
// SCAN_LIMIT=7). A small MAX7219 receiver model shifts data on serial-clock
// rise, captures one word per load rise and keeps the eight digit
// registers. Build with MAX7219_REINIT_EN to match a DUT built that way.
// ---------------------------------------------------------------------------
module tb_max7219_serial_driver;

    localparam int CLK_DIV  = 2;
    localparam int WORD_CYC = 34 * CLK_DIV;

`ifdef MAX7219_REINIT_EN
    localparam bit REINIT = 1'b1;
`else
    localparam bit REINIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [63:0] digits;
    logic        busy, done, sdout, sclk, sload;

    max7219_serial_driver #(
        .CLK_DIV   (CLK_DIV),
        .INTENSITY (4'h8),
        .SCAN_LIMIT(3'd7)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_en         (en),
        .i_start      (start),
        .i_digits     (digits),
        .o_busy       (busy),
        .o_done       (done),
        .o_serial_dout(sdout),
        .o_serial_clk (sclk),
        .o_serial_load(sload)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model
    logic [15:0] sh = '0;
    logic [15:0] cap_q[$];
    logic [7:0]  moc[1:8];
    int          sclk_rises = 0;
    int          load_rises = 0;
    int          proto_err = 0;

    always @(posedge sclk) begin
        sh = {sh[14:0], sdout};
        sclk_rises++;
    end

    always @(posedge sload) begin
        cap_q.push_back(sh);
        load_rises++;
        if (sh[11:8] >= 4'd1 && sh[11:8] <= 4'd8) moc[sh[11:8]] = sh[7:0];
    end

    // Load high must come with clock and data low; data must not move while
    // the serial clock is high.
    always @(negedge clk) begin
        if (sload && (sclk || sdout)) proto_err++;
        if (sclk && sdout !== sh[0]) proto_err++;
    end

    logic [15:0] cfgw[5] = '{16'h0900, 16'h0A08, 16'h0B07, 16'h0C01, 16'h0F00};

    task automatic start_frame(input logic [63:0] d, output int t);
        @(negedge clk);
        digits = d;
        en     = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = cyc;
    endtask

    task automatic wait_done(input int limit, output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input int t0, input bit cfg,
                               input logic [63:0] d);
        int n;
        int t;
        bit ok;
        int k;
        int bad;
        logic [15:0] exp;
        n = cfg ? 13 : 8;
        wait_done(n * WORD_CYC + 50, t, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no o_done expected within %0d cycles", name, n * WORD_CYC + 50);
        end else if (t - t0 !== n * WORD_CYC) begin
            n_fail++;
            $display("FAIL %s_done_latency: got %0d expected %0d", name, t - t0, n * WORD_CYC);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_in_done: got %b expected 0", name, busy);
        end
        n_chk++;
        if (cap_q.size() !== n) begin
            n_fail++;
            $display("FAIL %s_word_count: got %0d expected %0d", name, cap_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            k = cfg ? i - 5 : i;
            if (cfg && i < 5) exp = cfgw[i];
            else              exp = {4'h0, 4'(k + 1), d[8*k +: 8]};
            n_chk++;
            if (i >= cap_q.size()) begin
                n_fail++;
                $display("FAIL %s_word%0d: got none expected %h", name, i, exp);
            end else if (cap_q[i] !== exp) begin
                n_fail++;
                $display("FAIL %s_word%0d: got %h expected %h", name, i, cap_q[i], exp);
            end
        end
        bad = 0;
        for (int j = 0; j < 8; j++) if (moc[j+1] !== d[8*j +: 8]) bad++;
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s_moc_digits: got %0d wrong digits expected 0", name, bad);
        end
    endtask

    task automatic test_reset;
        int bad;
        int s0, l0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if ({busy, done, sdout, sclk, sload} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {busy, done, sdout, sclk, sload});
        end
        rst = 1'b0;
        s0 = sclk_rises;
        l0 = load_rises;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({busy, done, sdout, sclk, sload} !== 5'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %0d nonzero cycles expected 0", bad);
        end
        n_chk++;
        if (sclk_rises - s0 !== 0 || load_rises - l0 !== 0) begin
            n_fail++;
            $display("FAIL idle_edges: got %0d sclk %0d load expected 0 0", sclk_rises - s0, load_rises - l0);
        end
    endtask

    task automatic test_first_frame;
        int t0;
        cap_q.delete();
        start_frame({8{8'h7E}}, t0);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_busy: got %b expected 1", busy);
        end
        check_frame("first", t0, 1'b1, {8{8'h7E}});
    endtask

    task automatic test_second_frame;
        int t0;
        logic [63:0] d;
        d = 64'h8807_0605_0403_0201;
        cap_q.delete();
        start_frame(d, t0);
        check_frame("second", t0, REINIT, d);
    endtask

    task automatic test_snapshot;
        int t0;
        int l0;
        int bad;
        logic [63:0] d;
        d = 64'h3030_6D79_335B_5F70;
        cap_q.delete();
        start_frame(d, t0);
        repeat (300) @(negedge clk);
        digits = ~d;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_frame("snapshot", t0, REINIT, d);
        l0 = load_rises;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (busy) bad++;
        end
        n_chk++;
        if (bad !== 0 || load_rises !== l0) begin
            n_fail++;
            $display("FAIL snapshot_no_extra_frame: got %0d busy cycles %0d loads expected 0 0", bad, load_rises - l0);
        end
    endtask

    task automatic test_enable;
        int t0;
        int bad;
        logic [63:0] d;
        en     = 1'b0;
        digits = 64'h1111_2222_3333_4444;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy) bad++;
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL enable_low_start: got %0d busy cycles expected 0", bad);
        end
        d = 64'h6D5B_4F06_7F77_3F80;
        cap_q.delete();
        start_frame(d, t0);
        repeat (200) @(negedge clk);
        en = 1'b0;
        check_frame("enable_drop", t0, REINIT, d);
    endtask

    task automatic test_done_start;
        int t0;
        int t;
        bit ok;
        logic [63:0] d;
        d = 64'h0102_0408_1020_4080;
        start_frame(d, t0);
        start = 1'b1;
        wait_done((REINIT ? 13 : 8) * WORD_CYC + 50, t, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL done_start_first_timeout: got no o_done expected one");
        end
        cap_q.delete();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_start_ignored: got busy %b expected 0", busy);
        end
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_start_next_accept: got busy %b expected 1", busy);
        end
        t0 = cyc;
        start = 1'b0;
        check_frame("done_start", t0, REINIT, d);
    endtask

    task automatic test_reset_mid;
        int t0;
        int l0, s0;
        bit ok;
        logic [63:0] d;
        d = 64'hA5A5_5A5A_C3C3_3C3C;
        cap_q.delete();
        l0 = load_rises;
        start_frame(d, t0);
        ok = 1'b0;
        for (int i = 0; i < 4 * WORD_CYC; i++) begin
            if (load_rises - l0 >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        s0 = sclk_rises;
        for (int i = 0; i < WORD_CYC; i++) begin
            if (sclk_rises - s0 >= 8) break;
            @(negedge clk);
        end
        for (int i = 0; i < 2 * CLK_DIV + 2; i++) begin
            if (!sclk) break;
            @(negedge clk);
        end
        n_chk++;
        if (!ok || sclk_rises - s0 !== 8 || sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_reach_bit7: got loads %0d rises %0d sclk %b expected 3 8 0", load_rises - l0, sclk_rises - s0, sclk);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, sdout, sclk, sload} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", {busy, done, sdout, sclk, sload});
        end
        rst = 1'b0;
        l0 = load_rises;
        repeat (100) @(negedge clk);
        n_chk++;
        if (load_rises !== l0 || cap_q.size() !== 3) begin
            n_fail++;
            $display("FAIL reset_mid_no_latch: got %0d new loads %0d words expected 0 3", load_rises - l0, cap_q.size());
        end
        cap_q.delete();
        start_frame(d, t0);
        check_frame("after_reset", t0, 1'b1, d);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        start  = 1'b0;
        digits = '0;
        for (int i = 1; i <= 8; i++) moc[i] = '0;
        test_reset;
        test_first_frame;
        test_second_frame;
        test_snapshot;
        test_enable;
        test_done_start;
        test_reset_mid;
        n_chk++;
        if (proto_err !== 0) begin
            n_fail++;
            $display("FAIL protocol: got %0d violations expected 0", proto_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
